// File: rtl/resource_scheduler_pkg.sv
// Shared widths, source encoding and credit sizing for the weighted round-robin scheduler.
// Build-wide macros get defaults here so every later file in the bundle sees them.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef SRC_PORT1
`define SRC_PORT1 1'b0
`endif
`ifndef SRC_PORT2
`define SRC_PORT2 1'b1
`endif
`ifndef GRANT_CNT_WIDTH
`define GRANT_CNT_WIDTH 16
`endif

package resource_scheduler_pkg;
    localparam int ADDR_W   = `ADDRESS_WIDTH;
    localparam int ID_W     = `ID_WIDTH;
    localparam int CNT_W    = `GRANT_CNT_WIDTH;
    localparam int CREDIT_W = 4;

    typedef enum logic {
        SRC_P1 = `SRC_PORT1,
        SRC_P2 = `SRC_PORT2
    } src_e;
endpackage

// File: rtl/resource_scheduler_req_fifo2.sv
// Two-entry request FIFO; the full flag is kept as its own register so the
// upstream stall carries no combinational path from the consumer.
module req_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic             full_r;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses the push even when it is popped in the same cycle.
    assign push_ok = push && !full_r;
    assign pop_ok  = pop && (count != 2'd0);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + 2'd1;
        else if (pop_ok && !push_ok)
            count_nxt = count - 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            full_r <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= ~wr_ptr;
            if (pop_ok)
                rd_ptr <= ~rd_ptr;
            count  <= count_nxt;
            full_r <= (count_nxt == 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = full_r;
    assign empty = (count == 2'd0);
endmodule

// File: rtl/resource_scheduler.sv
// Weighted round-robin arbiter sharing one resource request port between two
// requesters, with per-port FIFOs, a registered issue stage and grant counters.
module resource_scheduler
    import resource_scheduler_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int ID_WIDTH      = ID_W,
    parameter int WEIGHT_1      = 2,
    parameter int WEIGHT_2      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] in_address_1,
    input  logic [ID_WIDTH-1:0]      in_id_1,
    input  logic                     in_valid_1,
    output logic                     out_stall_1,
    input  logic [ADDRESS_WIDTH-1:0] in_address_2,
    input  logic [ID_WIDTH-1:0]      in_id_2,
    input  logic                     in_valid_2,
    output logic                     out_stall_2,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic [ID_WIDTH-1:0]      out_id,
    output logic                     out_src,
    output logic                     out_valid,
    input  logic                     in_stall,
    output logic [CNT_W-1:0]         grant_cnt_1,
    output logic [CNT_W-1:0]         grant_cnt_2
);
    localparam int REQ_W = ADDRESS_WIDTH + ID_WIDTH;
    localparam logic [CREDIT_W-1:0] W1_C = CREDIT_W'(WEIGHT_1);
    localparam logic [CREDIT_W-1:0] W2_C = CREDIT_W'(WEIGHT_2);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CREDIT_W-1:0] weight_of(input src_e p);
        return (p == SRC_P1) ? W1_C : W2_C;
    endfunction

    function automatic src_e other_of(input src_e p);
        return (p == SRC_P1) ? SRC_P2 : SRC_P1;
    endfunction

    logic [REQ_W-1:0]    head_1;
    logic [REQ_W-1:0]    head_2;
    logic                full_1;
    logic                full_2;
    logic                empty_1;
    logic                empty_2;
    logic                pop_1;
    logic                pop_2;
    src_e                owner_r;
    logic [CREDIT_W-1:0] credit_r;
    logic                load_en;
    logic                owner_has;
    logic                other_has;
    logic                grant_vld_p0;
    src_e                grant_src_p0;
    logic [CREDIT_W-1:0] rem_p0;
    logic [REQ_W-1:0]    head_p0;
    logic [CNT_W-1:0]    cnt_1_p1;
    logic [CNT_W-1:0]    cnt_2_p1;

    req_fifo2 #(.WIDTH(REQ_W)) u_fifo_1 (
        .clk(clk), .reset(reset),
        .push(in_valid_1 && !full_1), .pop(pop_1),
        .wdata({in_address_1, in_id_1}), .rdata(head_1),
        .full(full_1), .empty(empty_1)
    );

    req_fifo2 #(.WIDTH(REQ_W)) u_fifo_2 (
        .clk(clk), .reset(reset),
        .push(in_valid_2 && !full_2), .pop(pop_2),
        .wdata({in_address_2, in_id_2}), .rdata(head_2),
        .full(full_2), .empty(empty_2)
    );

    assign out_stall_1 = full_1;
    assign out_stall_2 = full_2;
    assign load_en     = !out_valid || !in_stall;
    assign owner_has   = (owner_r == SRC_P1) ? !empty_1 : !empty_2;
    assign other_has   = (owner_r == SRC_P1) ? !empty_2 : !empty_1;

    // Stage p0: pick a winner; an idle slot leaves owner and credit untouched.
    always_comb begin
        grant_vld_p0 = 1'b0;
        grant_src_p0 = owner_r;
        if (load_en) begin
            if (owner_has) begin
                grant_vld_p0 = 1'b1;
            end else if (other_has) begin
                grant_vld_p0 = 1'b1;
                grant_src_p0 = other_of(owner_r);
            end
        end
        rem_p0 = (grant_src_p0 == owner_r) ? credit_r - 1'b1
                                           : weight_of(grant_src_p0) - 1'b1;
    end

    assign pop_1   = grant_vld_p0 && (grant_src_p0 == SRC_P1);
    assign pop_2   = grant_vld_p0 && (grant_src_p0 == SRC_P2);
    assign head_p0 = (grant_src_p0 == SRC_P1) ? head_1 : head_2;

    // Stage p1: registered issue towards the resource plus turn bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_address <= '0;
            out_id      <= '0;
            out_src     <= 1'b0;
            owner_r     <= SRC_P1;
            credit_r    <= W1_C;
            cnt_1_p1    <= '0;
            cnt_2_p1    <= '0;
        end else begin
            if (load_en)
                out_valid <= grant_vld_p0;
            if (grant_vld_p0) begin
                out_address <= head_p0[REQ_W-1:ID_WIDTH];
                out_id      <= head_p0[ID_WIDTH-1:0];
                out_src     <= grant_src_p0;
                if (rem_p0 == '0) begin
                    owner_r  <= other_of(grant_src_p0);
                    credit_r <= weight_of(other_of(grant_src_p0));
                end else begin
                    owner_r  <= grant_src_p0;
                    credit_r <= rem_p0;
                end
            end
            if (pop_1)
                cnt_1_p1 <= sat_inc(cnt_1_p1);
            if (pop_2)
                cnt_2_p1 <= sat_inc(cnt_2_p1);
        end
    end

    assign grant_cnt_1 = cnt_1_p1;
    assign grant_cnt_2 = cnt_2_p1;
endmodule

// File: tb/tb_resource_scheduler.sv
// Directed bench for resource_scheduler: a queue-based model of the weighted
// round-robin rules is stepped every clock and compared with the DUT each cycle.
module tb_resource_scheduler;
    import resource_scheduler_pkg::*;

    localparam int AW = ADDR_W;
    localparam int IW = ID_W;
    localparam int W1 = 2;
    localparam int W2 = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] in_address_1, in_address_2, out_address;
    logic [IW-1:0] in_id_1, in_id_2, out_id;
    logic          in_valid_1, in_valid_2, out_stall_1, out_stall_2;
    logic          out_src, out_valid, in_stall;
    logic [15:0]   grant_cnt_1, grant_cnt_2;

    always #5 clk = ~clk;

    resource_scheduler #(.ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .WEIGHT_1(W1), .WEIGHT_2(W2)) dut (
        .clk(clk), .reset(reset),
        .in_address_1(in_address_1), .in_id_1(in_id_1), .in_valid_1(in_valid_1), .out_stall_1(out_stall_1),
        .in_address_2(in_address_2), .in_id_2(in_id_2), .in_valid_2(in_valid_2), .out_stall_2(out_stall_2),
        .out_address(out_address), .out_id(out_id), .out_src(out_src), .out_valid(out_valid),
        .in_stall(in_stall), .grant_cnt_1(grant_cnt_1), .grant_cnt_2(grant_cnt_2)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [IW-1:0] id;
    } req_t;

    req_t sq1[$], sq2[$];   // requests waiting to be offered by each port
    req_t mf1[$], mf2[$];   // model of each port's FIFO contents
    int   glog[$];          // granted port (1/2) in issue order
    int   gcyc[$];          // cycle of each grant
    bit            m_valid;
    logic [AW-1:0] m_addr;
    logic [IW-1:0] m_id;
    int   m_src, m_owner, m_credit, m_cnt1, m_cnt2;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;

    function automatic req_t mk(input int a, input int id);
        req_t r;
        r.a  = AW'(a);
        r.id = IW'(id);
        return r;
    endfunction

    function automatic int wgt(input int p);
        return (p == 1) ? W1 : W2;
    endfunction

    function automatic int fsize(input int p);
        return (p == 1) ? mf1.size() : mf2.size();
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: cycle budget exhausted at cycle %0d", name, cyc);
    endtask

    task automatic model_reset();
        mf1.delete(); mf2.delete(); glog.delete(); gcyc.delete();
        m_valid = 0; m_addr = '0; m_id = '0; m_src = 0;
        m_owner = 1; m_credit = W1; m_cnt1 = 0; m_cnt2 = 0;
    endtask

    // One clock of the scheduler rules, using the inputs the DUT sees at this edge.
    task automatic model_step();
        bit   acc1, acc2;
        int   g, o, x, rem;
        req_t r;
        acc1 = in_valid_1 && (mf1.size() < 2);
        acc2 = in_valid_2 && (mf2.size() < 2);
        if (!m_valid || !in_stall) begin
            o = m_owner;
            x = 3 - o;
            g = 0;
            if (fsize(o) > 0) g = o;
            else if (fsize(x) > 0) g = x;
            if (g == 0) begin
                m_valid = 0;
            end else begin
                r = (g == 1) ? mf1.pop_front() : mf2.pop_front();
                m_valid = 1; m_addr = r.a; m_id = r.id; m_src = g - 1;
                rem = (g == o) ? m_credit - 1 : wgt(g) - 1;
                if (rem == 0) begin
                    m_owner = 3 - g; m_credit = wgt(3 - g);
                end else begin
                    m_owner = g; m_credit = rem;
                end
                if (g == 1) m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : 65535;
                else        m_cnt2 = (m_cnt2 < 65535) ? m_cnt2 + 1 : 65535;
                glog.push_back(g);
                gcyc.push_back(cyc);
            end
        end
        if (acc1) mf1.push_back(sq1.pop_front());
        if (acc2) mf2.push_back(sq2.pop_front());
    endtask

    task automatic compare_cycle();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_address", out_address, m_addr);
            chk("out_id", out_id, m_id);
            chk("out_src", out_src, m_src);
        end
        chk("out_stall_1", out_stall_1, mf1.size() == 2);
        chk("out_stall_2", out_stall_2, mf2.size() == 2);
        chk("grant_cnt_1", grant_cnt_1, m_cnt1);
        chk("grant_cnt_2", grant_cnt_2, m_cnt2);
    endtask

    task automatic drive();
        in_valid_1 = (sq1.size() > 0);
        in_valid_2 = (sq2.size() > 0);
        if (sq1.size() > 0) begin in_address_1 = sq1[0].a; in_id_1 = sq1[0].id; end
        if (sq2.size() > 0) begin in_address_2 = sq2[0].a; in_id_2 = sq2[0].id; end
    endtask

    task automatic tick();
        drive();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_cycle();
        cyc++;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((sq1.size() != 0 || sq2.size() != 0 || mf1.size() != 0 || mf2.size() != 0 || m_valid) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) timeout_fail("drain");
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases on a falling edge.
    task automatic do_reset();
        in_valid_1 = 0; in_valid_2 = 0; in_stall = 0;
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_address", out_address, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_stall_1", out_stall_1, 0);
        chk("rst_stall_2", out_stall_2, 0);
        chk("rst_cnt_1", grant_cnt_1, 0);
        chk("rst_cnt_2", grant_cnt_2, 0);
        sq1.delete(); sq2.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int k;
        reset = 1'b1; in_stall = 0;
        in_valid_1 = 0; in_valid_2 = 0;
        in_address_1 = '0; in_address_2 = '0; in_id_1 = '0; in_id_2 = '0;
        @(negedge clk);
        do_reset();

        // Single port-1 request: visible two edges after acceptance.
        sq1.push_back(mk('h10, 3));
        tick();
        chk("t1_idle_cycle1", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_address", out_address, 'h10);
        chk("t1_id", out_id, 3);
        chk("t1_src", out_src, 0);
        chk("t1_cnt_1", grant_cnt_1, 1);
        drain(20);

        // Both ports saturated: 2 grants to port 1, then 1 to port 2.
        do_reset();
        for (int i = 0; i < 22; i++) sq1.push_back(mk('h100 + i, i));
        for (int i = 0; i < 12; i++) sq2.push_back(mk('h200 + i, i));
        k = 0;
        while (m_cnt1 + m_cnt2 < 30 && k < 100) begin tick(); k++; end
        if (k >= 100) timeout_fail("t2_thirty_grants");
        chk("t2_cnt_1", grant_cnt_1, 20);
        chk("t2_cnt_2", grant_cnt_2, 10);
        for (int i = 0; i < 30 && i < glog.size(); i++)
            chk("t2_pattern", glog[i], (i % 3 == 2) ? 2 : 1);
        drain(60);

        // Port 2 alone: back-to-back issue, turn returns to port 1.
        do_reset();
        for (int i = 0; i < 5; i++) sq2.push_back(mk('h300 + i, i + 1));
        drain(40);
        chk("t3_grants", glog.size(), 5);
        if (gcyc.size() == 5) chk("t3_back_to_back", gcyc[4] - gcyc[0], 4);
        chk("t3_owner", m_owner, 1);
        chk("t3_credit", m_credit, 2);
        chk("t3_cnt_2", grant_cnt_2, 5);
        sq1.push_back(mk('h400, 7));
        sq2.push_back(mk('h500, 8));
        tick();
        tick();
        chk("t3_p1_first_valid", out_valid, 1);
        chk("t3_p1_first_src", out_src, 0);
        chk("t3_p1_first_addr", out_address, 'h400);
        drain(20);

        // Resource backpressure while both ports keep pushing.
        do_reset();
        in_stall = 1;
        for (int i = 0; i < 5; i++) sq1.push_back(mk('h600 + i, i));
        for (int i = 0; i < 4; i++) sq2.push_back(mk('h700 + i, i + 8));
        repeat (8) tick();
        chk("t4_hold_valid", out_valid, 1);
        chk("t4_hold_addr", out_address, 'h600);
        chk("t4_hold_src", out_src, 0);
        chk("t4_stall_1", out_stall_1, 1);
        chk("t4_stall_2", out_stall_2, 1);
        in_stall = 0;
        drain(60);
        chk("t4_cnt_1", grant_cnt_1, 5);
        chk("t4_cnt_2", grant_cnt_2, 4);

        // Reset arriving mid-stream with output held and FIFOs full.
        do_reset();
        in_stall = 1;
        for (int i = 0; i < 4; i++) sq1.push_back(mk('h800 + i, i));
        for (int i = 0; i < 4; i++) sq2.push_back(mk('h900 + i, i));
        repeat (6) tick();
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_stall_1", out_stall_1, 1);
        chk("t6_pre_stall_2", out_stall_2, 1);
        do_reset();
        sq1.push_back(mk('hA00, 1));
        sq2.push_back(mk('hB00, 2));
        tick();
        tick();
        chk("t6_first_valid", out_valid, 1);
        chk("t6_first_src", out_src, 0);
        chk("t6_first_addr", out_address, 'hA00);
        drain(20);

        // Counter saturation from a preloaded value.
        do_reset();
        #2 force dut.cnt_1_p1 = 16'hFFFD;
        m_cnt1 = 'hFFFD;
        #1 release dut.cnt_1_p1;
        for (int i = 0; i < 3; i++) sq1.push_back(mk('hC00 + i, i));
        drain(30);
        chk("t5_saturated", grant_cnt_1, 16'hFFFF);
        chk("t5_cnt_2", grant_cnt_2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
